// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows SW/SH/SB stores to a word-addressed memory,
// merging sub-word stores into the containing word by read-modify-write.
module store_narrow_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  st_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        timeout,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, FIN} state_t;
    localparam logic [15:0] LAST = 16'(MAX_WAIT - 1);
    state_t      state_q;
    logic [1:0]  off_q, type_q;
    logic [15:0] wdata_q, cnt_q;
    logic [31:0] rdata_q, mem_addr_q, mem_wdata_q, merge_d;
    logic        done_q, misalign_q, timeout_q, mem_rd_q, mem_wr_q, misaligned;
    assign misaligned = st_type == 2'b11 || (st_type == 2'b00 && |addr[1:0]) ||
                        (st_type == 2'b01 && addr[0]);
    // Little-endian lane insert over the word read back from memory
    always_comb begin
        merge_d = rdata_q;
        if (type_q == 2'b10) merge_d[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        else merge_d[{off_q[1], 4'b0000} +: 16] = wdata_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            off_q       <= 2'b00;
            type_q      <= 2'b00;
            wdata_q     <= 16'h0;
            cnt_q       <= 16'h0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    off_q      <= addr[1:0];
                    type_q     <= st_type;
                    wdata_q    <= wdata[15:0];
                    mem_addr_q <= {addr[31:2], 2'b00};
                    cnt_q      <= 16'h0;
                    if (misaligned) begin
                        state_q    <= FIN;
                        done_q     <= 1'b1;
                        misalign_q <= 1'b1;
                    end else if (st_type == 2'b00) begin
                        state_q     <= WR;
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= wdata;
                    end else begin
                        state_q  <= RD;
                        mem_rd_q <= 1'b1;
                    end
                end
                RD: if (mem_ready) begin
                    rdata_q  <= mem_rdata;
                    mem_rd_q <= 1'b0;
                    state_q  <= MERGE;
                end else if (cnt_q == LAST) begin
                    mem_rd_q  <= 1'b0;
                    timeout_q <= 1'b1;
                    done_q    <= 1'b1;
                    state_q   <= FIN;
                end else cnt_q <= cnt_q + 16'd1;
                MERGE: begin
                    mem_wdata_q <= merge_d;
                    mem_wr_q    <= 1'b1;
                    cnt_q       <= 16'h0;
                    state_q     <= WR;
                end
                WR: if (mem_ready) begin
                    mem_wr_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= FIN;
                end else if (cnt_q == LAST) begin
                    mem_wr_q  <= 1'b0;
                    timeout_q <= 1'b1;
                    done_q    <= 1'b1;
                    state_q   <= FIN;
                end else cnt_q <= cnt_q + 16'd1;
                FIN: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign timeout   = timeout_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: directed checks of store narrowing, merge, misalign, timeout and reset.
module tb_store_narrow_unit;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, mem_ready = 1'b0;
    logic [1:0]  st_type = 2'b00;
    logic [31:0] addr = 32'h0, wdata = 32'h0, mem_rdata = 32'h0;
    logic        busy, done, misalign, timeout, mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    int          passed = 0, total = 0;
    int          r_rd, r_wr, r_done, dn;
    logic [31:0] r_wd, r_ma;
    logic        r_mis, r_to, r_busy, r_done2;

    store_narrow_unit #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .st_type(st_type), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
        .timeout(timeout), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory answers each strobe after dly cycles of mem_ready low; cycle 1 is the one after the start edge.
    task automatic run(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] r, input int dly, input bit hold);
        int w = 0;
        r_rd = 0; r_wr = 0; r_done = 0; r_wd = 32'h0; r_ma = 32'h0; r_mis = 1'b0; r_to = 1'b0;
        st_type = t; addr = a; wdata = d; mem_rdata = r; start = 1'b1;
        @(negedge clk);
        start = hold;
        for (int c = 1; c <= 40 && r_done == 0; c++) begin
            if (mem_rd) r_rd++;
            if (mem_wr) begin r_wr++; r_wd = mem_wdata; end
            if (mem_rd || mem_wr) r_ma = mem_addr;
            if (done) begin r_done = c; r_mis = misalign; r_to = timeout; end
            if (mem_rd || mem_wr) begin mem_ready = (w == dly); w++; end
            else begin mem_ready = 1'b0; w = 0; end
            @(negedge clk);
        end
        start = 1'b0;
        mem_ready = 1'b0;
        r_busy = busy;
        r_done2 = done;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if ({busy, done, misalign, timeout, mem_rd, mem_wr} !== 6'b0) $display("FAIL reset_ctrl got=%b want=000000", {busy, done, misalign, timeout, mem_rd, mem_wr}); else passed++;
        total++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata}); else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word;
        run(2'b00, 32'h00000100, 32'h12345678, 32'h0, 0, 1'b0);
        total++; if (r_rd !== 0) $display("FAIL word_rd got=%0d want=0", r_rd); else passed++;
        total++; if (r_wr !== 1) $display("FAIL word_wr got=%0d want=1", r_wr); else passed++;
        total++; if (r_ma !== 32'h100) $display("FAIL word_addr got=%h want=00000100", r_ma); else passed++;
        total++; if (r_wd !== 32'h12345678) $display("FAIL word_wdata got=%h want=12345678", r_wd); else passed++;
        total++; if (r_done !== 2) $display("FAIL word_done_cycle got=%0d want=2", r_done); else passed++;
        total++; if ({r_mis, r_to} !== 2'b00) $display("FAIL word_flags got=%b want=00", {r_mis, r_to}); else passed++;
        total++; if ({r_busy, r_done2} !== 2'b00) $display("FAIL word_idle got=%b want=00", {r_busy, r_done2}); else passed++;
    endtask

    task automatic test_byte;
        run(2'b10, 32'h10000002, 32'hDEADBEEF, 32'h11223344, 0, 1'b0);
        total++; if ({r_rd, r_wr} !== {32'd1, 32'd1}) $display("FAIL byte_strobes got=%0d,%0d want=1,1", r_rd, r_wr); else passed++;
        total++; if (r_ma !== 32'h10000000) $display("FAIL byte_addr got=%h want=10000000", r_ma); else passed++;
        total++; if (r_wd !== 32'h11EF3344) $display("FAIL byte_wdata got=%h want=11ef3344", r_wd); else passed++;
        total++; if (r_done !== 4) $display("FAIL byte_done_cycle got=%0d want=4", r_done); else passed++;
        run(2'b10, 32'h00000203, 32'h000000AA, 32'h55667788, 0, 1'b0);
        total++; if (r_wd !== 32'hAA667788) $display("FAIL byte_lane3 got=%h want=aa667788", r_wd); else passed++;
        run(2'b10, 32'h00000200, 32'h12345678, 32'h55667788, 0, 1'b0);
        total++; if (r_wd !== 32'h55667778) $display("FAIL byte_lane0 got=%h want=55667778", r_wd); else passed++;
    endtask

    task automatic test_half_wait;
        run(2'b01, 32'h00000022, 32'hFFFFABCD, 32'h11223344, 3, 1'b0);
        total++; if ({r_rd, r_wr} !== {32'd4, 32'd4}) $display("FAIL half_strobes got=%0d,%0d want=4,4", r_rd, r_wr); else passed++;
        total++; if (r_wd !== 32'hABCD3344) $display("FAIL half_wdata got=%h want=abcd3344", r_wd); else passed++;
        total++; if (r_done !== 10) $display("FAIL half_done_cycle got=%0d want=10", r_done); else passed++;
        total++; if ({r_mis, r_to} !== 2'b00) $display("FAIL half_flags got=%b want=00", {r_mis, r_to}); else passed++;
        run(2'b01, 32'h00000200, 32'h12345678, 32'h55667788, 0, 1'b0);
        total++; if (r_wd !== 32'h55665678) $display("FAIL half_low got=%h want=55665678", r_wd); else passed++;
    endtask

    task automatic test_misalign;
        run(2'b01, 32'h00000101, 32'h1, 32'h0, 0, 1'b0);
        total++; if ({r_done, r_mis, r_to, r_rd, r_wr} !== {32'd1, 2'b10, 32'd0, 32'd0}) $display("FAIL mis_half got=done%0d mis%b to%b rd%0d wr%0d want=1 1 0 0 0", r_done, r_mis, r_to, r_rd, r_wr); else passed++;
        run(2'b00, 32'h00000102, 32'h1, 32'h0, 0, 1'b0);
        total++; if ({r_done, r_mis, r_to, r_rd, r_wr} !== {32'd1, 2'b10, 32'd0, 32'd0}) $display("FAIL mis_word got=done%0d mis%b to%b rd%0d wr%0d want=1 1 0 0 0", r_done, r_mis, r_to, r_rd, r_wr); else passed++;
        run(2'b11, 32'h00000100, 32'h1, 32'h0, 0, 1'b0);
        total++; if ({r_done, r_mis, r_to, r_rd, r_wr} !== {32'd1, 2'b10, 32'd0, 32'd0}) $display("FAIL mis_rsvd got=done%0d mis%b to%b rd%0d wr%0d want=1 1 0 0 0", r_done, r_mis, r_to, r_rd, r_wr); else passed++;
        total++; if (r_busy !== 1'b0) $display("FAIL mis_idle got=%b want=0", r_busy); else passed++;
    endtask

    task automatic test_timeout;
        run(2'b10, 32'h00000400, 32'h5A, 32'h0, 1000, 1'b0);
        total++; if (r_rd !== 4) $display("FAIL to_rd_cycles got=%0d want=4", r_rd); else passed++;
        total++; if (r_wr !== 0) $display("FAIL to_wr got=%0d want=0", r_wr); else passed++;
        total++; if ({r_done, r_to, r_mis} !== {32'd5, 2'b10}) $display("FAIL to_done got=cycle%0d to%b mis%b want=5 1 0", r_done, r_to, r_mis); else passed++;
        total++; if (r_busy !== 1'b0) $display("FAIL to_idle got=%b want=0", r_busy); else passed++;
    endtask

    task automatic test_reset_mid_access;
        st_type = 2'b10; addr = 32'h300; wdata = 32'h77; mem_rdata = 32'h0; mem_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        total++; if (mem_wr !== 1'b1) $display("FAIL rst_in_wr got=%b want=1", mem_wr); else passed++;
        rst = 1'b0;
        #1;
        total++; if ({busy, done, misalign, timeout, mem_rd, mem_wr} !== 6'b0) $display("FAIL rst_async_ctrl got=%b want=000000", {busy, done, misalign, timeout, mem_rd, mem_wr}); else passed++;
        total++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL rst_async_data got=%h want=0", {mem_addr, mem_wdata}); else passed++;
        dn = 0;
        repeat (2) begin @(negedge clk); if (done) dn++; end
        rst = 1'b1;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        total++; if ({dn, busy} !== {32'd0, 1'b0}) $display("FAIL rst_no_done got=dones%0d busy%b want=0 0", dn, busy); else passed++;
        run(2'b10, 32'h00000304, 32'h0000005A, 32'hFFFFFFFF, 0, 1'b0);
        total++; if ({r_wd, r_done} !== {32'hFFFFFF5A, 32'd4}) $display("FAIL rst_recover got=%h cycle%0d want=ffffff5a 4", r_wd, r_done); else passed++;
    endtask

    task automatic test_back_to_back;
        run(2'b10, 32'h00000501, 32'hCC, 32'h01020304, 0, 1'b1);
        total++; if ({r_done, r_wd} !== {32'd4, 32'h0102CC04}) $display("FAIL busy_start got=cycle%0d %h want=4 0102cc04", r_done, r_wd); else passed++;
        total++; if ({r_busy, r_done2} !== 2'b00) $display("FAIL busy_fin_start got=%b want=00", {r_busy, r_done2}); else passed++;
        dn = 0;
        repeat (5) begin @(negedge clk); if (done || busy) dn++; end
        total++; if (dn !== 0) $display("FAIL busy_extra got=%0d want=0", dn); else passed++;
        run(2'b00, 32'h00000600, 32'hCAFEF00D, 32'h0, 1, 1'b0);
        total++; if ({r_wd, r_done} !== {32'hCAFEF00D, 32'd3}) $display("FAIL b2b_word got=%h cycle%0d want=cafef00d 3", r_wd, r_done); else passed++;
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_half_wait;
        test_misalign;
        test_timeout;
        test_reset_mid_access;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
